// File: rtl/fir_pkg.sv
// Shared definitions for the FIR bank sequencer: sizes, state encoding and
// the triangular coefficient-layout helper.
package fir_pkg;

  localparam int unsigned MAX_ORDER    = 12;
  localparam int unsigned BLOCK_SIZE   = 4096;
  localparam int unsigned COEFF_W      = 12;
  localparam int unsigned SAMPLE_W     = 16;
  localparam int unsigned DONE_TIMEOUT = 256;
  localparam int unsigned NUM_COEFFS   = 78;
  localparam int unsigned ADDR_W       = 7;
  localparam int unsigned ORDER_W      = 4;
  localparam int unsigned COUNT_W      = 13;
  localparam int unsigned WAIT_W       = 9;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    STREAM,
    WAIT_DONE,
    REPORT
  } state_t;

  // First RAM address of order m: orders are packed as a triangle, m words each.
  function automatic logic [ADDR_W-1:0] coeff_base(input logic [ORDER_W-1:0] m);
    int unsigned mi;
    mi = 32'(m);
    return ADDR_W'((mi * (mi - 1)) / 2);
  endfunction

endpackage

// File: rtl/fir_coeff_walker.sv
// Walks the coefficient RAM once per block: one read per cycle over
// addresses 0..NUM_COEFFS-1, then a registered load strobe one cycle later
// tagged with the order that word belongs to.
// Ports:
//   iClock, iReset  clock, sync active-high reset
//   start           begin a walk (asserted for one cycle before the first read)
//   addr, read      RAM address and read strobe
//   load, m         bank load strobe and order, aligned with RAM read data
//   last_c          final load strobe is being issued this cycle
module fir_coeff_walker
  import fir_pkg::*;
(
  input  logic               iClock,
  input  logic               iReset,
  input  logic               start,
  output logic [ADDR_W-1:0]  addr,
  output logic               read,
  output logic               load,
  output logic [ORDER_W-1:0] m,
  output logic               last_c
);

  logic [ORDER_W-1:0] m_q;
  logic [ORDER_W-1:0] k_q;
  logic               last_read_c;

  // Last word is coefficient MAX_ORDER-1 of the highest order.
  assign last_read_c = read &&
      (addr == coeff_base(ORDER_W'(MAX_ORDER)) + ADDR_W'(MAX_ORDER - 1));

  // Read data lands one cycle after the final read, so the walk ends when a
  // load strobe has no read behind it.
  assign last_c = load & ~read;

  // Address and order/index counters.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      addr <= '0;
      read <= 1'b0;
      load <= 1'b0;
      m    <= '0;
      m_q  <= '0;
      k_q  <= '0;
    end else begin
      load <= read;
      m    <= read ? m_q : '0;
      if (start) begin
        addr <= '0;
        read <= 1'b1;
        m_q  <= ORDER_W'(1);
        k_q  <= '0;
      end else if (read) begin
        if (last_read_c) begin
          read <= 1'b0;
          addr <= '0;
        end else begin
          addr <= addr + ADDR_W'(1);
        end
        if (k_q == m_q - ORDER_W'(1)) begin
          m_q <= m_q + ORDER_W'(1);
          k_q <= '0;
        end else begin
          k_q <= k_q + ORDER_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fir_bank_sequencer.sv
// Sequences one analysis block through the FIR filter bank: clear, load all
// quantised coefficients, stream BLOCK_SIZE samples, wait for the bank's
// verdict and hand the winning order downstream over valid/ready.
// Ports:
//   iClock, iReset                 clock, sync active-high reset
//   iStart / oBusy                 block start (IDLE only) / not idle
//   oCoeffAddr, oCoeffRead, iCoeff coefficient RAM (data one cycle after read)
//   oBankReset, oBankLoad, oBankM, oBankCoeff   bank clear and coefficient load
//   iSampleValid, iSample, oSampleReady         sample source handshake
//   oBankValid, oBankSample        registered sample to bank
//   iBankDone, iBestOrder          bank completion and winning order
//   oResultValid, oBestOrder, iResultReady      result handshake
//   oTimeout                       sticky: bank never reported done
module fir_bank_sequencer
  import fir_pkg::*;
(
  input  logic                iClock,
  input  logic                iReset,
  input  logic                iStart,
  output logic                oBusy,
  output logic [ADDR_W-1:0]   oCoeffAddr,
  output logic                oCoeffRead,
  input  logic [COEFF_W-1:0]  iCoeff,
  output logic                oBankReset,
  output logic                oBankLoad,
  output logic [ORDER_W-1:0]  oBankM,
  output logic [COEFF_W-1:0]  oBankCoeff,
  input  logic                iSampleValid,
  input  logic [SAMPLE_W-1:0] iSample,
  output logic                oSampleReady,
  output logic                oBankValid,
  output logic [SAMPLE_W-1:0] oBankSample,
  input  logic                iBankDone,
  input  logic [ORDER_W-1:0]  iBestOrder,
  output logic                oResultValid,
  output logic [ORDER_W-1:0]  oBestOrder,
  output logic                oTimeout,
  input  logic                iResultReady
);

  state_t              state_q, state_d;
  logic [COUNT_W-1:0]  samp_cnt_q, samp_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [ORDER_W-1:0]  best_d;
  logic                timeout_d;
  logic                accept_c;
  logic                walk_last_c;

  assign accept_c = oSampleReady & iSampleValid;

  fir_coeff_walker u_walker (
    .iClock (iClock),
    .iReset (iReset),
    .start  (state_q == CLEAR),
    .addr   (oCoeffAddr),
    .read   (oCoeffRead),
    .load   (oBankLoad),
    .m      (oBankM),
    .last_c (walk_last_c)
  );

  // RAM read data is already aligned with the load strobe; zero it otherwise.
  assign oBankCoeff = oBankLoad ? iCoeff : '0;

  // Next-state and counter/result logic.
  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    wait_cnt_d = wait_cnt_q;
    best_d     = oBestOrder;
    timeout_d  = oTimeout;
    unique case (state_q)
      IDLE: begin
        if (iStart) state_d = CLEAR;
      end
      CLEAR: begin
        state_d    = LOAD;
        timeout_d  = 1'b0;
        samp_cnt_d = '0;
      end
      LOAD: begin
        if (walk_last_c) state_d = STREAM;
      end
      STREAM: begin
        if (accept_c) begin
          samp_cnt_d = samp_cnt_q + COUNT_W'(1);
          if (samp_cnt_q == COUNT_W'(BLOCK_SIZE - 1)) begin
            state_d    = WAIT_DONE;
            wait_cnt_d = '0;
          end
        end
      end
      WAIT_DONE: begin
        if (iBankDone) begin
          best_d  = iBestOrder;
          state_d = REPORT;
        end else if (wait_cnt_q == WAIT_W'(DONE_TIMEOUT - 1)) begin
          // Bank is stuck: report the cheapest order so the encoder still proceeds.
          timeout_d = 1'b1;
          best_d    = ORDER_W'(1);
          state_d   = REPORT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      REPORT: begin
        if (iResultReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs; status outputs follow state_d so
  // they are valid in the same cycle as the state they describe.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q      <= IDLE;
      samp_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      oBestOrder   <= '0;
      oTimeout     <= 1'b0;
      oBusy        <= 1'b0;
      oBankReset   <= 1'b0;
      oSampleReady <= 1'b0;
      oResultValid <= 1'b0;
      oBankValid   <= 1'b0;
      oBankSample  <= '0;
    end else begin
      state_q      <= state_d;
      samp_cnt_q   <= samp_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      oBestOrder   <= best_d;
      oTimeout     <= timeout_d;
      oBusy        <= (state_d != IDLE);
      oBankReset   <= (state_d == CLEAR);
      oSampleReady <= (state_d == STREAM);
      oResultValid <= (state_d == REPORT);
      oBankValid   <= accept_c;
      if (accept_c) oBankSample <= iSample;
    end
  end

endmodule

// File: tb/tb_fir_bank_sequencer.sv
// Directed bench for fir_bank_sequencer: coefficient walk, gapped streaming,
// result backpressure, timeout, mid-stream reset and ignored restarts.
module tb_fir_bank_sequencer;
  import fir_pkg::*;

  logic                iClock = 1'b0;
  logic                iReset;
  logic                iStart;
  logic                oBusy;
  logic [ADDR_W-1:0]   oCoeffAddr;
  logic                oCoeffRead;
  logic [COEFF_W-1:0]  iCoeff;
  logic                oBankReset;
  logic                oBankLoad;
  logic [ORDER_W-1:0]  oBankM;
  logic [COEFF_W-1:0]  oBankCoeff;
  logic                iSampleValid;
  logic [SAMPLE_W-1:0] iSample;
  logic                oSampleReady;
  logic                oBankValid;
  logic [SAMPLE_W-1:0] oBankSample;
  logic                iBankDone;
  logic [ORDER_W-1:0]  iBestOrder;
  logic                oResultValid;
  logic [ORDER_W-1:0]  oBestOrder;
  logic                oTimeout;
  logic                iResultReady;

  fir_bank_sequencer dut (
    .iClock(iClock), .iReset(iReset), .iStart(iStart), .oBusy(oBusy),
    .oCoeffAddr(oCoeffAddr), .oCoeffRead(oCoeffRead), .iCoeff(iCoeff),
    .oBankReset(oBankReset), .oBankLoad(oBankLoad), .oBankM(oBankM),
    .oBankCoeff(oBankCoeff), .iSampleValid(iSampleValid), .iSample(iSample),
    .oSampleReady(oSampleReady), .oBankValid(oBankValid), .oBankSample(oBankSample),
    .iBankDone(iBankDone), .iBestOrder(iBestOrder), .oResultValid(oResultValid),
    .oBestOrder(oBestOrder), .oTimeout(oTimeout), .iResultReady(iResultReady)
  );

  always #5 iClock = ~iClock;

  // Coefficient RAM holding RAM[a] = a, one-cycle read latency.
  logic [COEFF_W-1:0] ram_q = '0;
  always @(posedge iClock) if (oCoeffRead) ram_q <= {5'd0, oCoeffAddr};
  assign iCoeff = ram_q;

  wire [63:0] all_outs = {13'd0, oBusy, oCoeffAddr, oCoeffRead, oBankReset, oBankLoad,
                          oBankM, oBankCoeff, oSampleReady, oBankValid, oBankSample,
                          oResultValid, oBestOrder, oTimeout};

  int n_checks = 0;
  int n_errors = 0;
  int n_load, n_reset_pulse, n_bvalid, data_err, n_acc;
  logic [3:0]  load_m [128];
  logic [11:0] load_c [128];
  logic        exp_v;
  logic [15:0] exp_s;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_load = 0; n_reset_pulse = 0; n_bvalid = 0; data_err = 0; n_acc = 0;
  endtask

  // Per-cycle monitor: load strobes, clear pulses and the sample pipeline.
  task automatic observe();
    if (oBankLoad) begin
      if (n_load < 128) begin
        load_m[n_load] = oBankM;
        load_c[n_load] = oBankCoeff;
      end
      n_load++;
    end
    if (oBankReset) n_reset_pulse++;
    if (oBankValid) n_bvalid++;
    if (oBankValid !== exp_v || (exp_v && oBankSample !== exp_s)) data_err++;
  endtask

  // Inputs are set before calling; the DUT samples them at the next posedge.
  task automatic cyc();
    exp_v = oSampleReady & iSampleValid & ~iReset;
    exp_s = iSample;
    @(negedge iClock);
    observe();
  endtask

  task automatic start_and_load(input bit poke);
    int k;
    int idx;
    int werr;
    clear_stats();
    iStart = 1'b1;
    cyc();
    iStart = 1'b0;
    check_eq("clear_pulse", oBankReset, 1);
    check_eq("busy_clear", oBusy, 1);
    k = 0;
    do begin
      iStart = poke && (k == 10);
      cyc();
      k++;
      if (k == 1) check_eq("timeout_cleared", oTimeout, 0);
    end while (!oSampleReady && k < 200);
    iStart = 1'b0;
    check_eq("load_cycles", k, 80);
    check_eq("reset_pulses", n_reset_pulse, 1);
    check_eq("load_strobes", n_load, 78);
    idx = 0;
    werr = 0;
    for (int m = 1; m <= 12; m++) begin
      for (int kk = 0; kk < m; kk++) begin
        if (load_m[idx] !== 4'(m) || load_c[idx] !== 12'(idx)) werr++;
        idx++;
      end
    end
    check_eq("walk_order", werr, 0);
    check_eq("strobe0_m", load_m[0], 1);
    check_eq("strobe0_coeff", load_c[0], 0);
    check_eq("strobe2_m", load_m[2], 2);
    check_eq("strobe2_coeff", load_c[2], 2);
    check_eq("strobe77_m", load_m[77], 12);
    check_eq("strobe77_coeff", load_c[77], 77);
  endtask

  task automatic stream(input bit gaps, input bit poke, input int stop_at);
    int sc;
    bit tog;
    sc = 0;
    tog = 1'b0;
    while (oSampleReady && n_acc < stop_at && sc < 10000) begin
      tog = ~tog;
      iSampleValid = gaps ? tog : 1'b1;
      iSample = 16'(n_acc * 4951 + 165);
      iStart = poke && (n_acc == 1000);
      iBankDone = (n_acc == 50);
      iBestOrder = 4'd3;
      if (oSampleReady && iSampleValid) n_acc++;
      cyc();
      sc++;
    end
    iStart = 1'b0;
    iBankDone = 1'b0;
    iSampleValid = 1'b0;
  endtask

  task automatic finish_block(input bit no_done, input logic [3:0] best,
                              input int ready_low, input int done_wait);
    int w;
    int rv;
    int stable_err;
    logic [3:0] exp_best;
    check_eq("accepts", n_acc, 4096);
    check_eq("ready_low_after", oSampleReady, 0);
    iSampleValid = 1'b1;
    iSample = 16'hdead;
    repeat (3) cyc();
    iSampleValid = 1'b0;
    check_eq("bank_valid_pulses", n_bvalid, 4096);
    check_eq("sample_pipe", data_err, 0);
    check_eq("still_not_ready", oSampleReady, 0);
    check_eq("waiting_no_result", oResultValid, 0);
    check_eq("waiting_no_timeout", oTimeout, 0);
    w = 3;
    if (!no_done) begin
      repeat (done_wait) cyc();
      iBestOrder = best;
      iBankDone = 1'b1;
      cyc();
      iBankDone = 1'b0;
      iBestOrder = 4'd2;
      exp_best = best;
    end else begin
      while (!oResultValid && w < 400) begin
        cyc();
        w++;
      end
      check_eq("timeout_cycles", w, 256);
      check_eq("timeout_flag", oTimeout, 1);
      exp_best = 4'd1;
    end
    check_eq("result_valid", oResultValid, 1);
    check_eq("best_order", oBestOrder, exp_best);
    rv = 0;
    stable_err = 0;
    while (oResultValid && rv < 50) begin
      rv++;
      if (oBestOrder !== exp_best) stable_err++;
      iResultReady = (rv > ready_low);
      cyc();
    end
    iResultReady = 1'b0;
    check_eq("result_cycles", rv, ready_low + 1);
    check_eq("best_stable", stable_err, 0);
    check_eq("idle_busy", oBusy, 0);
    check_eq("loads_total", n_load, 78);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    iReset = 1'b1; iStart = 1'b0; iSampleValid = 1'b0; iSample = '0;
    iBankDone = 1'b0; iBestOrder = '0; iResultReady = 1'b0;
    clear_stats();
    repeat (3) cyc();
    check_eq("reset_outputs", all_outs, 64'd0);
    iReset = 1'b0;
    cyc();
    check_eq("idle_after_reset", oBusy, 0);

    // Gapped stream, result backpressure for 5 cycles, order 7.
    start_and_load(1'b0);
    stream(1'b1, 1'b0, 4096);
    finish_block(1'b0, 4'd7, 5, 10);

    // Restart requests during LOAD and STREAM must be ignored.
    start_and_load(1'b1);
    stream(1'b0, 1'b1, 4096);
    finish_block(1'b0, 4'd12, 0, 2);

    // Bank never reports done.
    start_and_load(1'b0);
    stream(1'b0, 1'b0, 4096);
    finish_block(1'b1, 4'd0, 0, 0);
    cyc();
    check_eq("timeout_sticky", oTimeout, 1);

    // Next block clears the timeout, then reset lands on sample 2000.
    start_and_load(1'b0);
    stream(1'b0, 1'b0, 2000);
    check_eq("accepts_before_reset", n_acc, 2000);
    iReset = 1'b1;
    iSampleValid = 1'b1;
    iSample = 16'h5a5a;
    cyc();
    check_eq("reset_mid_stream", all_outs, 64'd0);
    iReset = 1'b0;
    iSampleValid = 1'b0;
    cyc();
    check_eq("no_pulse_after_reset", n_bvalid, 2000);
    check_eq("idle_after_abort", oBusy, 0);

    // Full replay after the abort.
    start_and_load(1'b0);
    stream(1'b0, 1'b0, 4096);
    finish_block(1'b0, 4'd1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
